// File: rtl/instr_sequencer_pkg.sv
// Shared types and opcode constants for the instruction sequencer and its external decoder.
// Opcodes are stored 5 bits wide and zero-extended for comparison against the decoder output.
package instr_sequencer_pkg;

    localparam int PC_W_DEF = 10;
    localparam int OPW_DEF  = 5;
    localparam int IR_W     = 9;
    localparam int OPC_CMPW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_MODE,
        CLS_HALT
    } instr_cls_t;

    localparam logic [4:0] OP_HALT     = 5'h1F;
    localparam logic [4:0] OP_MODE     = 5'h1E;
    localparam logic [4:0] OP_LD       = 5'h1C;
    localparam logic [4:0] OP_ST       = 5'h1D;
    localparam logic [4:0] OP_BR       = 5'h18;
    localparam logic [4:0] OP_MODE_IMM = 5'h07;

    // Reg-immediate mode has no memory, branch or halt instructions; only the mode toggle.
    function automatic instr_cls_t classify(input logic [OPC_CMPW-1:0] op, input logic imm_mode);
        instr_cls_t cls;
        cls = CLS_ALU;
        if (imm_mode) begin
            if (op == OPC_CMPW'(OP_MODE_IMM)) cls = CLS_MODE;
        end else begin
            case (op)
                OPC_CMPW'(OP_HALT): cls = CLS_HALT;
                OPC_CMPW'(OP_MODE): cls = CLS_MODE;
                OPC_CMPW'(OP_LD):   cls = CLS_LD;
                OPC_CMPW'(OP_ST):   cls = CLS_ST;
                OPC_CMPW'(OP_BR):   cls = CLS_BR;
                default:            cls = CLS_ALU;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control
// for a small 9-bit-instruction core, with branch and mode handling.
//
// state  | meaning
// IDLE   | waiting for Start; PC and mode cleared on departure
// FETCH  | latch ROM word into ir
// DECODE | decoder settling cycle
// EXEC   | ALU enabled; instruction class and branch result captured
// MEM    | data memory request held until mem_ack
// WB     | register write, PC advance or branch, mode toggle
// HALT   | Done asserted until Start drops
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [IR_W-1:0] mach_code,
    input  logic [OPW-1:0]  opcode,
    input  logic            br_flag,
    input  logic [PC_W-1:0] br_target,
    input  logic            mem_ack,
    output logic [PC_W-1:0] prog_ctr,
    output logic [IR_W-1:0] ir,
    output logic            mode,
    output logic            alu_en,
    output logic            mem_req,
    output logic            mem_we,
    output logic            reg_we,
    output logic            Done
);

    state_t          state;
    state_t          state_nxt;
    instr_cls_t      cls_exec;
    instr_cls_t      cls_q;
    logic            br_flag_q;
    logic [PC_W-1:0] br_target_q;
    logic [PC_W-1:0] pc_nxt;

    assign cls_exec = classify(OPC_CMPW'(opcode), mode);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (Start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (cls_exec)
                    CLS_HALT:       state_nxt = ST_HALT;
                    CLS_LD, CLS_ST: state_nxt = ST_MEM;
                    default:        state_nxt = ST_WB;
                endcase
            end
            ST_MEM:    if (mem_ack) state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   if (!Start) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes decode only registered state, so they cannot glitch on input changes.
    assign alu_en  = (state == ST_EXEC);
    assign mem_req = (state == ST_MEM);
    assign mem_we  = (state == ST_MEM) && (cls_q == CLS_ST);
    assign reg_we  = (state == ST_WB) && ((cls_q == CLS_ALU) || (cls_q == CLS_LD));
    assign Done    = (state == ST_HALT);

    assign pc_nxt = ((cls_q == CLS_BR) && br_flag_q) ? br_target_q : prog_ctr + PC_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prog_ctr    <= '0;
            ir          <= '0;
            mode        <= 1'b0;
            cls_q       <= CLS_ALU;
            br_flag_q   <= 1'b0;
            br_target_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        prog_ctr <= '0;
                        mode     <= 1'b0;
                    end
                end
                ST_FETCH: ir <= mach_code;
                // Branch inputs are only valid during EXEC, so hold them for WB.
                ST_EXEC: begin
                    cls_q       <= cls_exec;
                    br_flag_q   <= br_flag;
                    br_target_q <= br_target;
                end
                ST_WB: begin
                    prog_ctr <= pc_nxt;
                    if (cls_q == CLS_MODE) mode <= ~mode;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM array and a simple mode-aware decoder
// surround the DUT; each task checks one behaviour against hand-computed values.
module tb_instr_sequencer;

    localparam int PC_W = 10;
    localparam int OPW  = 5;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            Start = 1'b0;
    logic [8:0]      mach_code;
    logic [OPW-1:0]  opcode;
    logic            br_flag = 1'b0;
    logic [PC_W-1:0] br_target = '0;
    logic            mem_ack = 1'b0;
    logic [PC_W-1:0] prog_ctr;
    logic [8:0]      ir;
    logic            mode;
    logic            alu_en;
    logic            mem_req;
    logic            mem_we;
    logic            reg_we;
    logic            Done;

    logic [8:0] rom [0:1023];
    int tests_run = 0;
    int tests_failed = 0;

    instr_sequencer #(.PC_W(PC_W), .OPW(OPW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .mach_code(mach_code),
        .opcode(opcode), .br_flag(br_flag), .br_target(br_target), .mem_ack(mem_ack),
        .prog_ctr(prog_ctr), .ir(ir), .mode(mode), .alu_en(alu_en),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .Done(Done)
    );

    always #5 Clk = ~Clk;

    assign mach_code = rom[prog_ctr];
    // External decoder: mode 0 uses ir[4:0], mode 1 uses the 3-bit immediate-form opcode.
    assign opcode = mode ? {2'b00, ir[2:0]} : ir[4:0];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h001;
    endtask

    task automatic do_reset();
        Start = 1'b0; mem_ack = 1'b0; br_flag = 1'b0; br_target = '0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] ir_seen;
        logic       en_seen;
        clear_rom();
        rom[0] = 9'h015;
        Reset = 1'b1;
        #3;
        tests_run++;
        if ({prog_ctr, ir, mode} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got pc=%0h ir=%0h mode=%0b expected all 0", prog_ctr, ir, mode);
        end
        tests_run++;
        if ({alu_en, mem_req, mem_we, reg_we, Done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %05b expected 00000", {alu_en, mem_req, mem_we, reg_we, Done});
        end
        tick();
        Reset = 1'b0;
        ir_seen = '0; en_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            ir_seen = ir_seen | ir;
            en_seen = en_seen | alu_en;
        end
        tests_run++;
        if ({ir_seen, en_seen} !== 10'h0) begin
            tests_failed++;
            $display("FAIL idle_without_start: got ir=%0h alu_en=%0b expected 0 0", ir_seen, en_seen);
        end
        Start = 1'b1;
        tick(); tick();
        Start = 1'b0;
        tests_run++;
        if (ir !== 9'h015) begin
            tests_failed++;
            $display("FAIL first_start_fetch: got ir=%0h expected 15", ir);
        end
        tick();
        tests_run++;
        if (alu_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_start_exec: got alu_en=%0b expected 1", alu_en);
        end
    endtask

    task automatic test_alu_halt();
        int we_cnt = 0, en_cnt = 0, done_cyc = 0;
        logic [8:0] ir_c2 = '0;
        do_reset();
        clear_rom();
        rom[0] = 9'h003; rom[1] = 9'h005; rom[2] = 9'h01F;
        Start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (reg_we) we_cnt++;
            if (alu_en) en_cnt++;
            if (Done && done_cyc == 0) done_cyc = c;
            if (c == 2) ir_c2 = ir;
        end
        tests_run++;
        if (done_cyc !== 12) begin
            tests_failed++;
            $display("FAIL halt_cycle: got %0d expected 12", done_cyc);
        end
        tests_run++;
        if (prog_ctr !== 10'd2) begin
            tests_failed++;
            $display("FAIL halt_pc: got %0h expected 2", prog_ctr);
        end
        tests_run++;
        if (we_cnt !== 2 || en_cnt !== 3) begin
            tests_failed++;
            $display("FAIL alu_pulses: got reg_we=%0d alu_en=%0d expected 2 3", we_cnt, en_cnt);
        end
        tests_run++;
        if (ir_c2 !== 9'h003 || Done !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_hold: got ir_c2=%0h Done=%0b expected 3 1", ir_c2, Done);
        end
        Start = 1'b0;
        tick();
        tests_run++;
        if (Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_release: got Done=%0b expected 0", Done);
        end
    endtask

    task automatic test_load();
        int req_cnt = 0, we_cnt = 0, we_cyc = 0;
        logic st_seen = 1'b0;
        logic [PC_W-1:0] pc8 = '1, pc9 = '1;
        do_reset();
        clear_rom();
        rom[0] = 9'h01C; rom[1] = 9'h01F;
        Start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (mem_req) req_cnt++;
            if (mem_we) st_seen = 1'b1;
            if (reg_we) begin we_cnt++; we_cyc = c; end
            if (c == 8) pc8 = prog_ctr;
            if (c == 9) pc9 = prog_ctr;
            if (c == 1) Start = 1'b0;
            if (c == 2) mem_ack = 1'b1;
            if (c == 3) mem_ack = 1'b0;
            if (c == 7) mem_ack = 1'b1;
            if (c == 8) mem_ack = 1'b0;
        end
        tests_run++;
        if (req_cnt !== 4 || st_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_mem_req: got cycles=%0d mem_we=%0b expected 4 0", req_cnt, st_seen);
        end
        tests_run++;
        if (we_cnt !== 1 || we_cyc !== 8) begin
            tests_failed++;
            $display("FAIL load_reg_we: got count=%0d cycle=%0d expected 1 8", we_cnt, we_cyc);
        end
        tests_run++;
        if (pc8 !== 10'd0 || pc9 !== 10'd1) begin
            tests_failed++;
            $display("FAIL load_next_fetch: got pc8=%0h pc9=%0h expected 0 1", pc8, pc9);
        end
    endtask

    task automatic test_store();
        do_reset();
        clear_rom();
        rom[0] = 9'h01D;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if ({mem_req, mem_we} !== 2'b11) begin
            tests_failed++;
            $display("FAIL store_req: got req=%0b we=%0b expected 1 1", mem_req, mem_we);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests_run++;
        if ({mem_req, reg_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL store_wb: got req=%0b reg_we=%0b expected 0 0", mem_req, reg_we);
        end
        tick();
        tests_run++;
        if (prog_ctr !== 10'd1) begin
            tests_failed++;
            $display("FAIL store_next_pc: got %0h expected 1", prog_ctr);
        end
    endtask

    task automatic test_branch();
        do_reset();
        clear_rom();
        rom[0] = 9'h018; rom[5] = 9'h018; rom[6] = 9'h01F; rom[32] = 9'h01F;
        br_flag = 1'b1; br_target = 10'd5;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        br_flag = 1'b0; br_target = 10'h155;
        tick();
        tests_run++;
        if (prog_ctr !== 10'd5) begin
            tests_failed++;
            $display("FAIL branch_captured: got %0h expected 5", prog_ctr);
        end
        br_flag = 1'b1; br_target = 10'h020;
        repeat (4) tick();
        tests_run++;
        if (prog_ctr !== 10'h020) begin
            tests_failed++;
            $display("FAIL branch_taken: got %0h expected 20", prog_ctr);
        end
        repeat (3) tick();
        tests_run++;
        if (Done !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_target_halt: got Done=%0b expected 1", Done);
        end
        do_reset();
        br_flag = 1'b1; br_target = 10'd5;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        br_flag = 1'b0; br_target = 10'h020;
        repeat (4) tick();
        tests_run++;
        if (prog_ctr !== 10'd6) begin
            tests_failed++;
            $display("FAIL branch_not_taken: got %0h expected 6", prog_ctr);
        end
    endtask

    task automatic test_mode();
        int we_cnt = 0;
        logic m4 = 1'bx, m5 = 1'bx, m8 = 1'bx, m9 = 1'bx;
        do_reset();
        clear_rom();
        rom[0] = 9'h01E; rom[1] = 9'h007; rom[2] = 9'h01F;
        Start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) Start = 1'b0;
            if (reg_we) we_cnt++;
            if (c == 4) m4 = mode;
            if (c == 5) m5 = mode;
            if (c == 8) m8 = mode;
            if (c == 9) m9 = mode;
        end
        tests_run++;
        if ({m4, m5, m8, m9} !== 4'b0110) begin
            tests_failed++;
            $display("FAIL mode_toggle: got %b%b%b%b expected 0110", m4, m5, m8, m9);
        end
        tests_run++;
        if (we_cnt !== 0 || Done !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_no_write: got reg_we=%0d Done=%0b expected 0 1", we_cnt, Done);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        clear_rom();
        rom[0] = 9'h018; rom[1023] = 9'h001;
        br_flag = 1'b1; br_target = 10'h3FF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (prog_ctr !== 10'h3FF) begin
            tests_failed++;
            $display("FAIL wrap_setup: got %0h expected 3ff", prog_ctr);
        end
        repeat (4) tick();
        tests_run++;
        if (prog_ctr !== 10'h000) begin
            tests_failed++;
            $display("FAIL pc_wrap: got %0h expected 0", prog_ctr);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic d3 = 1'bx;
        do_reset();
        clear_rom();
        rom[0] = 9'h01C;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL mem_wait: got mem_req=%0b expected 1", mem_req);
        end
        mem_ack = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_req, Done, alu_en, prog_ctr, ir} !== 22'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_mem: got req=%0b done=%0b pc=%0h ir=%0h expected all 0", mem_req, Done, prog_ctr, ir);
        end
        tick();
        Reset = 1'b0;
        tick();
        tests_run++;
        if ({mem_req, reg_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL ack_discarded: got req=%0b reg_we=%0b expected 0 0", mem_req, reg_we);
        end
        mem_ack = 1'b0;
        rom[0] = 9'h01F;
        Start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) d3 = Done;
        end
        Start = 1'b0;
        tests_run++;
        if ({d3, Done, prog_ctr} !== {2'b01, 10'd0}) begin
            tests_failed++;
            $display("FAIL restart_after_reset: got d3=%0b d4=%0b pc=%0h expected 0 1 0", d3, Done, prog_ctr);
        end
    endtask

    initial begin
        test_reset();
        test_alu_halt();
        test_load();
        test_store();
        test_branch();
        test_mode();
        test_wrap();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program counter width.
REQ-002 Parameter OPW, default 5, opcode width.
REQ-003 Clk  input  1  single clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-005 Start  input  1  level request to run program from address 0.
REQ-006 mach_code  input  9  instruction ROM data at prog_ctr.
REQ-007 opcode  input  OPW  decoded opcode of ir under current mode.
REQ-008 br_flag  input  1  ALU condition flag, valid in EXEC.
REQ-009 br_target  input  PC_W  branch LUT output, valid in EXEC.
REQ-010 mem_ack  input  1  data memory completion strobe.
REQ-011 prog_ctr  output  PC_W  instruction fetch address.
REQ-012 ir  output  9  latched instruction to decoder.
REQ-013 mode  output  1  decoder mode: 0 reg-reg, 1 reg-immediate.
REQ-014 alu_en  output  1  ALU operand/flag capture enable.
REQ-015 mem_req  output  1  data memory request, held until ack.
REQ-016 mem_we  output  1  store qualifier, valid with mem_req.
REQ-017 reg_we  output  1  register file write enable, one cycle.
REQ-018 Done  output  1  program halted.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-020 IDLE: Start=1 -> FETCH, prog_ctr<=0, mode<=0; else stay.
REQ-021 FETCH: ir<=mach_code; -> DECODE.
REQ-022 DECODE: -> EXEC unconditionally (decoder settling cycle).
REQ-023 EXEC: alu_en=1; HALT opcode -> HALT; LD/ST -> MEM; all else -> WB.
REQ-024 MEM: mem_req=1, mem_we=1 only for ST; stay until mem_ack=1, then -> WB; mem_ack outside MEM ignored.
REQ-025 WB: reg_we=1 for ALU ops and LD, 0 for ST, BR, MODE; -> FETCH.
REQ-026 WB: prog_ctr<=br_target (captured in EXEC) if BR and br_flag captured in EXEC =1, else prog_ctr+1 modulo 2^PC_W (max wraps to 0).
REQ-027 WB: MODE opcode toggles mode; effective from next FETCH.
REQ-028 Opcodes, mode 0: 5'h1F HALT, 5'h1E MODE, 5'h1C LD, 5'h1D ST, 5'h18 BR; mode 1: 5'h07 MODE, no memory/branch/halt.
REQ-029 HALT: Done=1; Start=0 -> IDLE; Start held 1 stays HALT (no auto-restart).
REQ-030 Start while not IDLE/HALT ignored.
REQ-031 Latency: non-memory instruction 4 cycles; memory instruction 5+N cycles, N = cycles mem_ack low in MEM.
REQ-032 alu_en, mem_req, reg_we, Done strictly Moore (state-decoded), glitch-free.

Reset
REQ-033 Reset=1: state IDLE, prog_ctr 0, ir 0, mode 0, all enables 0, Done 0, asynchronously.
REQ-034 Reset mid-MEM drops mem_req same cycle; pending ack discarded.
REQ-035 Reset release: first Start-qualified edge leaves IDLE; none earlier.

Structure
REQ-036 Shared package holds state enum, opcode constants, PC_W default; decoder and sequencer import it.
REQ-037 Single module, no sub-modules; PC next-address mux inline.

Verification
REQ-038 Start=1, ROM {0:ALU, 1:ALU, 2:HALT} -> Done=1 on cycle 12 after Start, prog_ctr=2, reg_we pulsed twice.
REQ-039 LD at addr 0, mem_ack after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, reg_we once, next FETCH at cycle 9.
REQ-040 BR at addr 5, br_flag=1, br_target=10'h020 -> prog_ctr=0x020; br_flag=0 -> prog_ctr=6.
REQ-041 MODE at addr 0, then mode-1 opcode 3'b111 at addr 1 -> mode 0->1 after first WB, 1->0 after second.
REQ-042 prog_ctr=10'h3FF non-branch -> wraps to 0.
REQ-043 Reset pulse during MEM -> mem_req 0 immediately, IDLE, prog_ctr 0, Done 0; Start restarts at 0.
